// File: rtl/store_serializer_pkg.sv
// Shared types and constants for the store serializer: FSM states, Size encodings
// and the byte-count lookup used when a store is accepted.
package store_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_B1  = 2'b00;
  localparam logic [1:0] SIZE_B2  = 2'b01;
  localparam logic [1:0] SIZE_B4  = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;

  // Three-bit byte count per Size code, index 0 in the low bits; reserved maps to 0.
  localparam logic [11:0] BYTE_COUNT_LUT = {3'd0, 3'd4, 3'd2, 3'd1};

  function automatic logic [2:0] byte_count(input logic [1:0] size);
    logic [3:0] idx;
    idx = {2'b00, size} * 4'd3;
    return BYTE_COUNT_LUT[idx +: 3];
  endfunction

endpackage

// File: rtl/store_serializer_if.sv
// Request and byte-memory bus of the store serializer; slave is the serializer's view.
interface store_serializer_if #(parameter int ADDR_W = 16);

  logic              Start;
  logic [31:0]       I;
  logic [ADDR_W-1:0] Addr;
  logic [1:0]        Size;
  logic              MemReady;
  logic              MemWrEn;
  logic [ADDR_W-1:0] MemAddr;
  logic [7:0]        MemData;
  logic              Busy;
  logic              Done;
  logic              Err;

  modport master (
    output Start, I, Addr, Size, MemReady,
    input  MemWrEn, MemAddr, MemData, Busy, Done, Err
  );

  modport slave (
    input  Start, I, Addr, Size, MemReady,
    output MemWrEn, MemAddr, MemData, Busy, Done, Err
  );

endinterface

// File: rtl/store_shift_reg.sv
// 32-bit byte shift register feeding MemData. Byte order: MSB-first by default,
// LSB-first when STORE_SER_LSB_FIRST_EN is defined.
module store_shift_reg
  import store_serializer_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        load,
  input  logic        shift,
  input  logic [1:0]  size,
  input  logic [31:0] din,
  output logic [7:0]  dout
);

  logic [31:0] sr;
  logic [31:0] aligned;
  logic [31:0] shifted;

  // Unused byte lanes load as zero, so the register drains to 0 after the last byte.
`ifdef STORE_SER_LSB_FIRST_EN
  always_comb begin
    aligned = din;
    case (size)
      SIZE_B1: aligned = {24'h000000, din[7:0]};
      SIZE_B2: aligned = {16'h0000, din[15:0]};
      default: aligned = din;
    endcase
    shifted = {8'h00, sr[31:8]};
  end
  assign dout = sr[7:0];
`else
  always_comb begin
    aligned = din;
    case (size)
      SIZE_B1: aligned = {din[7:0], 24'h000000};
      SIZE_B2: aligned = {din[15:0], 16'h0000};
      default: aligned = din;
    endcase
    shifted = {sr[23:0], 8'h00};
  end
  assign dout = sr[31:24];
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)     sr <= '0;
    else if (load)  sr <= aligned;
    else if (shift) sr <= shifted;
  end

endmodule

// File: rtl/store_serializer.sv
// Serializes a 1/2/4-byte store into byte writes with MemReady stall support.
// Byte order selected by STORE_SER_LSB_FIRST_EN (see store_shift_reg).
module store_serializer
  import store_serializer_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  store_serializer_if.slave   bus
);

  state_t            state;
  logic [2:0]        remaining;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_en;
  logic              busy;
  logic              done;
  logic              err;
  logic              accept;
  logic              load;
  logic              shift;
  logic [7:0]        byte_out;

  assign accept = (state == IDLE) && bus.Start;
  assign load   = accept && (bus.Size != SIZE_RSV);
  assign shift  = (state == WRITE) && bus.MemReady;

  store_shift_reg u_shift (
    .Clock (Clock),
    .Reset (Reset),
    .load  (load),
    .shift (shift),
    .size  (bus.Size),
    .din   (bus.I),
    .dout  (byte_out)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      remaining <= '0;
      addr_q    <= '0;
      wr_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (accept) begin
            busy <= 1'b1;
            if (bus.Size == SIZE_RSV) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= WRITE;
              wr_en     <= 1'b1;
              addr_q    <= bus.Addr;
              remaining <= byte_count(bus.Size);
            end
          end
        end
        WRITE: begin
          if (bus.MemReady) begin
            if (remaining == 3'd1) begin
              state     <= DONE;
              wr_en     <= 1'b0;
              addr_q    <= '0;
              remaining <= '0;
              done      <= 1'b1;
            end else begin
              addr_q    <= addr_q + ADDR_W'(1);
              remaining <= remaining - 3'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          remaining <= '0;
          addr_q    <= '0;
          wr_en     <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          err       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MemWrEn = wr_en;
  assign bus.MemAddr = addr_q;
  assign bus.MemData = byte_out;
  assign bus.Busy    = busy;
  assign bus.Done    = done;
  assign bus.Err     = err;

endmodule

// File: tb/tb_store_serializer.sv
// Self-checking bench for store_serializer: directed scenarios plus randomized stores
// checked against a byte-list reference model.
module tb_store_serializer;
    import store_serializer_pkg::*;

    localparam int ADDR_W = 16;

    logic Clock = 1'b0;
    logic Reset = 1'b0;

    store_serializer_if #(.ADDR_W(ADDR_W)) bus();

    store_serializer #(.ADDR_W(ADDR_W)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int exp_count(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    // Byte k (0-based, in write order) of an n-byte store of d.
    function automatic logic [7:0] exp_byte(input logic [31:0] d, input int n, input int k);
        logic [31:0] v;
`ifdef STORE_SER_LSB_FIRST_EN
        v = d >> (8 * k);
`else
        v = d >> (8 * (n - 1 - k));
`endif
        return v[7:0];
    endfunction

    // Called 1 time unit after a rising edge with the DUT idle.
    // mode: 0 = MemReady always high, 1 = random MemReady, 2 = first byte stalled 3 cycles.
    task automatic run_store(input logic [31:0] d, input logic [15:0] a, input logic [1:0] sz,
                             input int mode, input bit b2b,
                             input logic [31:0] nd, input logic [15:0] na, input logic [1:0] nsz);
        int n = exp_count(sz);
        int k = 0;
        int cyc = 0;
        int stall = 0;
        int first_hold = 0;
        bit rdy;
        bus.Start = 1'b1;
        bus.I = d;
        bus.Addr = a;
        bus.Size = sz;
        bus.MemReady = 1'b1;
        @(posedge Clock); #1;
        bus.Start = 1'b0;
        bus.I = $urandom;
        bus.Addr = 16'($urandom);
        bus.Size = 2'($urandom);
        cyc = 1;
        if (n == 0) begin
            chk("rsv_done", {31'd0, bus.Done}, 32'd1);
            chk("rsv_err", {31'd0, bus.Err}, 32'd1);
            chk("rsv_busy", {31'd0, bus.Busy}, 32'd1);
            chk("rsv_wren", {31'd0, bus.MemWrEn}, 32'd0);
            chk("rsv_data", {24'd0, bus.MemData}, 32'd0);
        end else begin
            while (k < n && cyc < 64) begin
                chk("wr_en", {31'd0, bus.MemWrEn}, 32'd1);
                chk("addr", {16'd0, bus.MemAddr}, {16'd0, 16'(a + k)});
                chk("data", {24'd0, bus.MemData}, {24'd0, exp_byte(d, n, k)});
                chk("busy", {31'd0, bus.Busy}, 32'd1);
                chk("no_done", {31'd0, bus.Done}, 32'd0);
                if (cyc == 1) begin
                    bus.Start = 1'b1;
                    bus.I = 32'hAAAAAAAA;
                end else begin
                    bus.Start = 1'b0;
                end
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = ($urandom_range(0, 2) != 0);
                    default: rdy = !(k == 0 && stall < 3);
                endcase
                bus.MemReady = rdy;
                if (k == 0) first_hold++;
                @(posedge Clock); #1;
                cyc++;
                if (rdy) k++;
                else if (k == 0) stall++;
            end
            bus.Start = 1'b0;
            if (k < n) chk("timeout", 32'd0, 32'd1);
            chk("done", {31'd0, bus.Done}, 32'd1);
            chk("done_err", {31'd0, bus.Err}, 32'd0);
            chk("done_busy", {31'd0, bus.Busy}, 32'd1);
            chk("done_wren", {31'd0, bus.MemWrEn}, 32'd0);
            chk("done_addr", {16'd0, bus.MemAddr}, 32'd0);
            chk("done_data", {24'd0, bus.MemData}, 32'd0);
            if (mode == 0) chk("latency", cyc, n + 1);
            if (mode == 2) chk("stall_hold", first_hold, 32'd4);
        end
        if (b2b) begin
            bus.Start = 1'b1;
            bus.I = nd;
            bus.Addr = na;
            bus.Size = nsz;
        end
        @(posedge Clock); #1;
        chk("idle_done", {31'd0, bus.Done}, 32'd0);
        chk("idle_err", {31'd0, bus.Err}, 32'd0);
        chk("idle_busy", {31'd0, bus.Busy}, 32'd0);
        chk("idle_wren", {31'd0, bus.MemWrEn}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [15:0] ra;
        logic [1:0]  rs;
        int hold;
        bus.Start = 1'b0;
        bus.I = '0;
        bus.Addr = '0;
        bus.Size = '0;
        bus.MemReady = 1'b0;
        #12;
        chk("rst_wren", {31'd0, bus.MemWrEn}, 32'd0);
        chk("rst_addr", {16'd0, bus.MemAddr}, 32'd0);
        chk("rst_data", {24'd0, bus.MemData}, 32'd0);
        chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
        chk("rst_done", {31'd0, bus.Done}, 32'd0);
        chk("rst_err", {31'd0, bus.Err}, 32'd0);
        Reset = 1'b1;
        @(posedge Clock); #1;

        run_store(32'hDEADBEEF, 16'h0100, 2'b10, 0, 1'b0, '0, '0, '0);
        run_store(32'h12345678, 16'hFFFF, 2'b01, 2, 1'b0, '0, '0, '0);
        run_store(32'h0BADF00D, 16'h1234, 2'b11, 0, 1'b0, '0, '0, '0);
        run_store(32'hDEADBEEF, 16'h0100, 2'b10, 0, 1'b1, 32'hC0FFEE11, 16'hFFFE, 2'b10);
        run_store(32'hC0FFEE11, 16'hFFFE, 2'b10, 0, 1'b0, '0, '0, '0);
        run_store(32'h000000A5, 16'hFFFF, 2'b00, 0, 1'b0, '0, '0, '0);

        for (int t = 0; t < 24; t++) begin
            rd = $urandom;
            ra = 16'($urandom);
            rs = 2'($urandom);
            run_store(rd, ra, rs, 1, 1'b0, '0, '0, '0);
        end

        // Abandon a 4-byte store after two bytes by asserting reset mid-cycle.
        bus.Start = 1'b1;
        bus.I = 32'h11223344;
        bus.Addr = 16'h0200;
        bus.Size = 2'b10;
        bus.MemReady = 1'b1;
        @(posedge Clock); #1;
        bus.Start = 1'b0;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        chk("pre_rst_wren", {31'd0, bus.MemWrEn}, 32'd1);
        chk("pre_rst_addr", {16'd0, bus.MemAddr}, 32'h0202);
        #2;
        Reset = 1'b0;
        #1;
        chk("arst_wren", {31'd0, bus.MemWrEn}, 32'd0);
        chk("arst_addr", {16'd0, bus.MemAddr}, 32'd0);
        chk("arst_data", {24'd0, bus.MemData}, 32'd0);
        chk("arst_busy", {31'd0, bus.Busy}, 32'd0);
        chk("arst_done", {31'd0, bus.Done}, 32'd0);
        hold = 0;
        repeat (2) begin
            @(posedge Clock); #1;
            if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) hold++;
        end
        chk("rst_hold_quiet", hold, 32'd0);
        #2;
        Reset = 1'b1;
        run_store(32'h0000005A, 16'h0020, 2'b00, 0, 1'b0, '0, '0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/store_serializer.md
STORE_SERIALIZER -- requirements
Module: store_serializer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, width of byte-memory address.
REQ-002 SHALL have port Clock  input  1  system clock, rising-edge active.
REQ-003 SHALL have port Reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Start  input  1  request to begin a store; sampled only in IDLE.
REQ-005 SHALL have port I  input  32  word to be stored.
REQ-006 SHALL have port Addr  input  ADDR_W  base byte address.
REQ-007 SHALL have port Size  input  2  store width: 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = reserved.
REQ-008 SHALL have port MemReady  input  1  memory accepts the presented byte at this edge.
REQ-009 SHALL have port MemWrEn  output  1  byte write strobe.
REQ-010 SHALL have port MemAddr  output  ADDR_W  byte address being written.
REQ-011 SHALL have port MemData  output  8  byte being written.
REQ-012 SHALL have port Busy  output  1  high in WRITE and DONE.
REQ-013 SHALL have port Done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port Err  output  1  one-cycle pulse on reserved Size, coincident with Done.

Function
REQ-015 SHALL implement the FSM states IDLE, WRITE and DONE.
REQ-016 In IDLE with Start=1 and Size legal, the block SHALL latch I, Addr and byte count (1, 2 or 4) and enter WRITE on the next edge.
REQ-017 In IDLE with Start=1 and Size=11, the block SHALL enter DONE with Err latched, performing no memory write.
REQ-018 In WRITE, MemWrEn SHALL be 1, MemAddr SHALL be base+index (index 0..count-1), and MemData SHALL be the current byte.
REQ-019 A byte SHALL be committed only at an edge where MemWrEn=1 and MemReady=1; with MemReady=0, MemAddr and MemData SHALL hold stable (stall, unbounded).
REQ-020 Default byte order SHALL be MSB-first: Size 4 writes I[31:24], I[23:16], I[15:8], I[7:0] to Addr..Addr+3; Size 2 writes I[15:8], I[7:0]; Size 1 writes I[7:0].
REQ-021 Byte order SHALL be the inverse of a left-shifting byte-assembling data register, so a read-back of the same count reconstructs the word.
REQ-022 On the edge committing the last byte, the block SHALL enter DONE; DONE SHALL last exactly one cycle with Done=1, then return to IDLE.
REQ-023 Latency SHALL be count+1 cycles from Start to Done with MemReady held high.
REQ-024 MemAddr SHALL wrap modulo 2^ADDR_W (for example, base all-ones followed by 0).
REQ-025 Start SHALL be ignored while Busy=1; Start in the same cycle Done=1 SHALL NOT be accepted. Back-to-back accept SHALL occur one cycle after DONE.
REQ-026 Outside WRITE, MemWrEn SHALL be 0, and MemAddr and MemData SHALL be 0.
REQ-027 Latched I, Addr and Size SHALL be unaffected by input changes after acceptance.

Reset
REQ-028 Reset low SHALL immediately force IDLE and clear all outputs and internal registers to 0, including mid-WRITE; the partial store SHALL be abandoned with no Done.
REQ-029 After Reset deasserts, the first Start SHALL be accepted at the next rising edge.

Configuration
REQ-030 With macro STORE_SER_LSB_FIRST_EN defined, byte order SHALL be LSB-first: Size 4 writes I[7:0], I[15:8], I[23:16], I[31:24] to Addr..Addr+3; Size 2 writes I[7:0], I[15:8].
REQ-031 Without the macro, REQ-020 order SHALL apply; all other behaviour SHALL be identical.

Structure
REQ-032 The shared package SHALL hold the FSM state enum (IDLE, WRITE, DONE), the Size encodings, and a byte-count lookup constant.
REQ-033 The 32-bit data shift register SHALL be an optional sub-module, store_shift_reg, with load/shift-by-8 controls (MSB-side or LSB-side per macro); the FSM and address counter SHALL stay in store_serializer.

Verification
REQ-034 Size=10, I=0xDEADBEEF, Addr=0x0100, MemReady=1 -> bytes DE, AD, BE, EF at 0x0100..0x0103 on consecutive cycles; Done 5 cycles after Start; Busy for 5 cycles.
REQ-035 Same stimulus with STORE_SER_LSB_FIRST_EN -> bytes EF, BE, AD, DE at 0x0100..0x0103.
REQ-036 Size=01, I=0x12345678, Addr=0xFFFF, MemReady low for 3 cycles on the first byte -> 0x56 held at 0xFFFF for 4 cycles, then 0x78 at 0x0000; Done once.
REQ-037 Size=11 -> no MemWrEn; Done=1 and Err=1 for one cycle, 1 cycle after Start.
REQ-038 Start re-pulsed with I=0xAAAAAAAA during an active Size=10 store -> ignored; the original bytes complete unchanged; a Start in the cycle after DONE is accepted.
REQ-039 Reset low after the 2nd byte of a Size=10 store -> all outputs 0 asynchronously, no Done; a fresh Size=00 store of 0x5A at 0x0020 completes normally.
